// File: rtl/serial_link.sv
// Bit-serial host link: shifts in a MID_W+DATA_W work frame on RxC and shifts out a WORD_W
// result word on TxC. All host strobes are synchronised into clk before use.
module serial_link #(
    parameter int MID_W       = 256,
    parameter int DATA_W      = 256,
    parameter int WORD_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              RxD,
    input  logic              RxC,
    input  logic              RxTxR,
    output logic [MID_W-1:0]  midstate,
    output logic [DATA_W-1:0] data2,
    output logic              rx_done,
    output logic              TxD,
    input  logic              TxC,
    input  logic              send,
    input  logic [WORD_W-1:0] word,
    output logic              busy
);

    localparam int FRAME_W  = MID_W + DATA_W;
    localparam int RX_CNT_W = $clog2(FRAME_W + 1);
    localparam int TX_CNT_W = $clog2(WORD_W + 1);

    logic [SYNC_STAGES-1:0] r_rxd_sync;
    logic [SYNC_STAGES-1:0] r_rxc_sync;
    logic [SYNC_STAGES-1:0] r_txc_sync;
    logic [SYNC_STAGES-1:0] r_rst_sync;
    logic                   r_rxc_dly;
    logic                   r_txc_dly;

    logic [FRAME_W-2:0]     r_rx_shift;
    logic [RX_CNT_W-1:0]    r_rx_cnt;
    logic [WORD_W-1:0]      r_tx_shift;
    logic [TX_CNT_W-1:0]    r_tx_cnt;

    logic                   w_rxd;
    logic                   w_link_rst;
    logic                   w_rxc_rise;
    logic                   w_txc_rise;
    logic [FRAME_W-1:0]     w_frame;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rxd_sync <= '0;
            r_rxc_sync <= '0;
            r_txc_sync <= '0;
            r_rst_sync <= '0;
            r_rxc_dly  <= 1'b0;
            r_txc_dly  <= 1'b0;
        end else begin
            r_rxd_sync <= {r_rxd_sync[SYNC_STAGES-2:0], RxD};
            r_rxc_sync <= {r_rxc_sync[SYNC_STAGES-2:0], RxC};
            r_txc_sync <= {r_txc_sync[SYNC_STAGES-2:0], TxC};
            r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], RxTxR};
            r_rxc_dly  <= r_rxc_sync[SYNC_STAGES-1];
            r_txc_dly  <= r_txc_sync[SYNC_STAGES-1];
        end
    end

    assign w_rxd      = r_rxd_sync[SYNC_STAGES-1];
    assign w_link_rst = r_rst_sync[SYNC_STAGES-1];
    assign w_rxc_rise = r_rxc_sync[SYNC_STAGES-1] & ~r_rxc_dly;
    assign w_txc_rise = r_txc_sync[SYNC_STAGES-1] & ~r_txc_dly;
    // The completed frame includes the bit arriving on the current rise.
    assign w_frame    = {r_rx_shift, w_rxd};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_shift <= '0;
            r_rx_cnt   <= '0;
            midstate   <= '0;
            data2      <= '0;
            rx_done    <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (w_link_rst) begin
                r_rx_shift <= '0;
                r_rx_cnt   <= '0;
            end else if (w_rxc_rise) begin
                r_rx_shift <= w_frame[FRAME_W-2:0];
                if (r_rx_cnt == RX_CNT_W'(FRAME_W - 1)) begin
                    midstate <= w_frame[FRAME_W-1:DATA_W];
                    data2    <= w_frame[DATA_W-1:0];
                    rx_done  <= 1'b1;
                    r_rx_cnt <= '0;
                end else begin
                    r_rx_cnt <= r_rx_cnt + RX_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            busy       <= 1'b0;
        end else if (w_link_rst) begin
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            busy       <= 1'b0;
        end else if (!busy) begin
            if (send) begin
                r_tx_shift <= word;
                r_tx_cnt   <= '0;
                busy       <= 1'b1;
            end
        end else if (w_txc_rise) begin
            r_tx_shift <= {r_tx_shift[WORD_W-2:0], 1'b0};
            if (r_tx_cnt == TX_CNT_W'(WORD_W - 1)) begin
                r_tx_cnt <= '0;
                busy     <= 1'b0;
            end else begin
                r_tx_cnt <= r_tx_cnt + TX_CNT_W'(1);
            end
        end
    end

    // The shifter is all-zero whenever idle (fully shifted out or cleared), so its MSB is a
    // glitch-free TxD straight from a flop.
    assign TxD = r_tx_shift[WORD_W-1];

endmodule

// File: tb/tb_serial_link.sv
// Directed-sequence bench for serial_link with randomized frames and a queue-based
// reference model of the host link.
module tb_serial_link;

    localparam int MID_W   = 256;
    localparam int DATA_W  = 256;
    localparam int WORD_W  = 32;
    localparam int FRAME_W = MID_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              RxD;
    logic              RxC;
    logic              RxTxR;
    logic [MID_W-1:0]  midstate;
    logic [DATA_W-1:0] data2;
    logic              rx_done;
    logic              TxD;
    logic              TxC;
    logic              send;
    logic [WORD_W-1:0] word;
    logic              busy;

    serial_link #(
        .MID_W(MID_W), .DATA_W(DATA_W), .WORD_W(WORD_W), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .RxD(RxD), .RxC(RxC), .RxTxR(RxTxR),
        .midstate(midstate), .data2(data2), .rx_done(rx_done), .TxD(TxD),
        .TxC(TxC), .send(send), .word(word), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(posedge clk) if (rx_done === 1'b1) done_cnt <= done_cnt + 1;

    // Reference model: bits accepted since the last link reset; every 512th bit publishes a frame.
    bit                 q_bits[$];
    logic [FRAME_W-1:0] exp_frame = '0;
    int                 exp_done = 0;

    function automatic void model_rx(bit b);
        q_bits.push_back(b);
        if (q_bits.size() == FRAME_W) begin
            for (int i = 0; i < FRAME_W; i++) exp_frame[FRAME_W-1-i] = q_bits[i];
            q_bits.delete();
            exp_done++;
        end
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_bit(input bit b);
        RxD = b;
        step(2);
        RxC = 1'b1;
        step(5);
        RxC = 1'b0;
        step(5);
        model_rx(b);
    endtask

    task automatic rx_frame(input logic [FRAME_W-1:0] f);
        for (int i = 0; i < FRAME_W; i++) rx_bit(f[FRAME_W-1-i]);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_midstate"}, midstate, exp_frame[FRAME_W-1:DATA_W]);
        chk({tag, "_data2"}, data2, exp_frame[DATA_W-1:0]);
        chk({tag, "_rx_done_count"}, 256'(done_cnt), 256'(exp_done));
    endtask

    task automatic do_send(input logic [WORD_W-1:0] w);
        send = 1'b1;
        word = w;
        step(1);
        send = 1'b0;
        word = $urandom;
        chk("busy_after_send", busy, 1'b1);
    endtask

    // Host side of transmit: sample TxD while TxC is low, then raise TxC.
    task automatic tx_run(input logic [WORD_W-1:0] w_exp, input int nbits, input int send_at);
        logic [WORD_W-1:0] ref_w;
        ref_w = w_exp;
        for (int i = 0; i < nbits; i++) begin
            if (i == send_at) begin
                send = 1'b1;
                word = 32'hFFFF_FFFF;
                step(1);
                send = 1'b0;
            end
            step(5);
            chk($sformatf("tx_bit%0d", i), TxD, ref_w[WORD_W-1-i]);
            chk($sformatf("tx_busy%0d", i), busy, 1'b1);
            TxC = 1'b1;
            step(5);
            TxC = 1'b0;
        end
    endtask

    logic [FRAME_W-1:0] f1;
    logic [FRAME_W-1:0] f2;
    logic [WORD_W-1:0]  wr;

    initial begin
        reset_n = 1'b0; RxD = 1'b0; RxC = 1'b0; RxTxR = 1'b0;
        TxC = 1'b0; send = 1'b0; word = '0;

        // Reset with strobes toggling
        for (int i = 0; i < 6; i++) begin
            RxC = ~RxC; TxC = ~TxC; RxD = ~RxD; send = 1'b1; word = $urandom;
            step(2);
        end
        chk("rst_midstate", midstate, '0);
        chk("rst_data2", data2, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_TxD", TxD, 1'b0);
        chk("rst_rx_done", rx_done, 1'b0);
        RxC = 1'b0; TxC = 1'b0; RxD = 1'b0; send = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(5);

        // Frame 1: anchor the ends with the known work values, middle randomized
        for (int i = 0; i < FRAME_W / 32; i++) f1[i*32 +: 32] = $urandom;
        f1[FRAME_W-1 -: 32] = 32'h2b3f8126;
        f1[31:0]            = 32'hc14bfc31;
        rx_frame(f1);
        check_rx("frame1");
        chk("frame1_vs_stimulus", midstate, f1[FRAME_W-1:DATA_W]);

        // Partial frame, then link reset with an RxC rise discarded under it
        for (int i = 0; i < 100; i++) rx_bit(1'($urandom));
        check_rx("partial_held");
        RxTxR = 1'b1;
        q_bits.delete();
        step(4);
        RxD = 1'b1;
        RxC = 1'b1;
        step(5);
        RxC = 1'b0;
        step(5);
        check_rx("during_link_rst");
        RxTxR = 1'b0;
        step(6);

        // Frame 2 must replace frame 1 exactly, nothing from the partial bits
        for (int i = 0; i < FRAME_W / 32; i++) f2[i*32 +: 32] = $urandom;
        f2[FRAME_W-1] = 1'b1;
        f2[0]         = 1'b1;
        rx_frame(f2);
        check_rx("frame2");
        chk("frame2_data2_vs_stimulus", data2, f2[DATA_W-1:0]);

        // Transmit the known word
        chk("idle_busy", busy, 1'b0);
        chk("idle_TxD", TxD, 1'b0);
        do_send(32'h01D0_08DC);
        tx_run(32'h01D0_08DC, WORD_W, -1);
        step(5);
        chk("tx1_busy_done", busy, 1'b0);
        chk("tx1_TxD_done", TxD, 1'b0);

        // Send while busy is ignored
        do_send(32'h01D0_08DC);
        tx_run(32'h01D0_08DC, WORD_W, 10);
        step(5);
        chk("tx2_busy_done", busy, 1'b0);
        chk("tx2_TxD_done", TxD, 1'b0);

        // Abort mid-transmit, send ignored while link reset is held
        wr = $urandom | 32'h8000_0000;
        do_send(wr);
        tx_run(wr, 5, -1);
        RxTxR = 1'b1;
        step(4);
        chk("abort_busy", busy, 1'b0);
        chk("abort_TxD", TxD, 1'b0);
        send = 1'b1;
        word = 32'hFFFF_FFFF;
        step(1);
        send = 1'b0;
        step(2);
        chk("send_during_rst_busy", busy, 1'b0);
        chk("send_during_rst_TxD", TxD, 1'b0);
        RxTxR = 1'b0;
        step(6);
        do_send(32'hA5A5_A5A5);
        tx_run(32'hA5A5_A5A5, WORD_W, -1);
        step(5);
        chk("tx3_busy_done", busy, 1'b0);
        chk("tx3_TxD_done", TxD, 1'b0);

        // Received frame is unaffected by transmit activity and link resets
        check_rx("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_link.md
Name: serial_link

Overview:
- Host-facing bit-serial link for the miner core.
- Receives a 512-bit work frame (midstate + data2) over a host-clocked serial line and presents it as parallel registers.
- Shifts a 32-bit result word (golden nonce) back to the host over a second host-clocked line.
- All host strobes are asynchronous to clk and are synchronized internally; sits between the board serial pins and the hash control unit.

Parameters:
- MID_W, 256, midstate width (first part of frame).
- DATA_W, 256, data2 width (second part of frame).
- WORD_W, 32, transmit word width.
- SYNC_STAGES, 2, synchronizer flops on RxD, RxC, TxC, RxTxR (minimum 2).

Ports:
- clk  input  1  system/hash clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- RxD  input  1  serial receive data from host.
- RxC  input  1  host receive strobe; RxD is sampled on its rising edge.
- RxTxR  input  1  host link reset, active high, level; clears both bit counters.
- midstate  output  MID_W  last complete frame, first MID_W bits.
- data2  output  DATA_W  last complete frame, remaining DATA_W bits.
- rx_done  output  1  one-clk pulse when midstate/data2 update.
- TxD  output  1  serial transmit data to host.
- TxC  input  1  host transmit strobe; host samples TxD before its rising edge.
- send  input  1  request to transmit word.
- word  input  WORD_W  word to transmit, captured on accepted send.
- busy  output  1  transmit in progress.

Behaviour:
- Reset (reset_n=0, async):
  - midstate=0, data2=0, rx_done=0, busy=0, TxD=0.
  - Bit counters, shift registers and synchronizers cleared.
- Synchronization:
  - RxD, RxC, TxC, RxTxR each pass through SYNC_STAGES flops.
  - One extra flop on RxC and TxC provides edge detection.
  - A rise is detected in the cycle where the synced value is 1 and the delayed value is 0.
  - RxD is taken from its synced stage in that same cycle.
  - Host timing requirement: RxC/TxC high ≥3 clk and low ≥3 clk; RxD stable ≥1 clk before RxC rise until 3 clk after.
- Receive:
  - Detected RxC rise: rx_shift <= {rx_shift[510:0], RxD_sync}; rx_cnt++.
  - Bits arrive MSB first; the first bit becomes midstate[MID_W-1].
  - On the rise that completes bit MID_W+DATA_W:
    - {midstate, data2} <= the completed frame, including the bit arriving on this rise.
    - rx_done=1 for one clk; rx_cnt wraps to 0.
  - midstate/data2 hold between frames; they are never cleared by RxTxR, only by reset_n.
- Transmit:
  - Idle: busy=0, TxD=0.
  - send=1 while busy=0 captures word into tx_shift, tx_cnt=0, busy=1 next clk.
  - send while busy=1 is ignored (word not re-captured).
  - While busy: TxD = tx_shift[WORD_W-1] (MSB first).
  - Each detected TxC rise shifts tx_shift left by 1 and increments tx_cnt.
  - After the WORD_W-th rise: busy=0, TxD=0.
- RxTxR (synced level = 1):
  - rx_cnt=0, rx_shift=0, busy=0, tx_cnt=0, TxD=0.
  - send is ignored while asserted.
  - Takes priority over a simultaneous RxC/TxC edge (that bit is discarded) and over a simultaneous send.
  - Mid-frame RxTxR discards the partial frame; the next RxC rise is bit 0.
- Counters are wide enough for 512 (rx) and WORD_W (tx); no other wrap-around.

Test Plan:
- Reset: hold reset_n=0 with toggling strobes -> midstate=0, data2=0, busy=0, TxD=0, rx_done=0.
- Frame receive: clock in 512 bits, midstate=2b3f8126…2619c0b5, data2=0000…39f3001b6b7b8d4dc14bfc31, MSB first -> outputs equal values exactly; rx_done single pulse ~3 clk after the 512th RxC rise.
- Partial frame + RxTxR: send 100 bits, pulse RxTxR, then send a full new frame -> outputs equal the new frame only; prior outputs held until then.
- Transmit: send=1 with word=0x01D0_08DC -> busy=1; TxD sampled before each of 32 TxC rises yields 0x01D008DC MSB first; busy=0 after 32nd rise.
- Send while busy: second send with word=0xFFFFFFFF mid-transfer -> transmitted bits still 0x01D008DC; busy drops normally.
- Abort: RxTxR mid-transmit -> busy=0, TxD=0; a following send=1 with word=0xA5A5A5A5 transmits cleanly.
